bsg_down_assembler: RTL and testbench
=====================================

Name: bsg_down_assembler

Overview:
Core-side assembler directly downstream of the per-channel downstream FIFOs.
- Consumes the per-channel 32-bit core words (valid/yumi) in strict round-robin channel order.
- Packs WORDS consecutive words into one OUT_W-bit core word and presents it on a valid/yumi output register.
- Channel enable mask allows disabled/calibrating channels to be skipped without breaking striping order.

Parameters:
NUM_CH, 2, number of downstream channels feeding the block
CH_W, 32, width of one channel core word
WORDS, 2, channel words per output word (OUT_W = WORDS*CH_W, default 64)

Ports:
clk  in  1  core clock
rst  in  1  reset
ch_data_i  in  NUM_CH*CH_W  channel words; channel c at bits [c*CH_W +: CH_W]
ch_valid_i  in  NUM_CH  channel word available
ch_yumi_o  out  NUM_CH  channel word consumed this cycle (one-hot or zero)
ch_en_i  in  NUM_CH  channel enable mask (quasi-static)
data_o  out  WORDS*CH_W  assembled core word
valid_o  out  1  data_o holds an unconsumed word
yumi_i  in  1  core consumes data_o this cycle
err_o  out  1  latched enable mask is all zero

Behaviour:
- Clock clk; reset rst, synchronous, active-high.
- Reset values:
  - valid_o=0, data_o=0, ch_yumi_o=0, err_o=0.
  - cnt=0, rptr=0, en_r=all ones, accumulator=0.
  - Reset mid-assembly discards the partial word and any pending output.
- State:
  - en_r: latched mask.
  - rptr: current channel, log2 NUM_CH bits.
  - cnt: words held, 0..WORDS-1.
  - acc: (WORDS-1)*CH_W bits.
  - Output register plus valid_o.
- Mask update happens only when idle, i.e. cnt==0 and no accept this cycle. If ch_en_i != en_r: en_r<=ch_en_i and rptr<=lowest set bit of ch_en_i. An all-zero mask sets rptr<=0.
- err_o = (en_r==0), registered.
- Accept condition: accept = ch_valid_i[rptr] & en_r[rptr] & room.
  - room = (cnt<WORDS-1) | ~valid_o | yumi_i.
  - ch_yumi_o[rptr]=accept; all other bits 0.
  - Combinational from inputs. No dependency of ch_valid_i on ch_yumi_o is allowed.
- Strict order: a valid word on any channel other than rptr is never taken.
- On accept with cnt<WORDS-1: word stored at acc slot cnt; cnt++.
- On accept with cnt==WORDS-1:
  - data_o <= {word, acc}, i.e. word k lands at bits [k*CH_W +: CH_W], LSB first.
  - valid_o<=1; cnt<=0.
- On every accept: rptr advances to the next set bit of en_r after rptr, circular. With a single enabled channel, rptr stays put.
- Output handshake:
  - yumi_i with valid_o and no completing accept: valid_o<=0.
  - Completing accept in the same cycle as yumi_i: new word loads, valid_o stays 1. This gives full throughput.
  - yumi_i while valid_o=0 is illegal: it is ignored and flagged by a bench assertion.
- Latency: final word accepted at cycle t -> valid_o=1 at t+1.
- Throughput: one channel word per cycle; one output word per WORDS cycles.
- Backpressure: valid_o=1 and yumi_i=0.
  - Assembly continues up to cnt=WORDS-1.
  - The completing word is then held upstream with ch_yumi_o=0.
  - data_o stays stable.

Decomposition:
- Package bsg_down_pkg:
  - Constants: NUM_CH_DEF, CH_W_DEF, WORDS_DEF.
  - Function clog2.
  - Typedef for the channel index.
- One sub-module, bsg_down_rr_next: combinational next-enabled-channel search (circular priority from rptr+1) plus lowest-set-bit for mask reload.

Test Plan:
1. Defaults, en=11, ch0 streams 0xA0..., ch1 streams 0xB0..., yumi_i=1 -> ch_yumi_o alternates 01,10; data_o=0xB0000000_A0000000 one cycle after the ch1 accept; a new valid_o every 2 cycles.
2. yumi_i=0 with valid_o=1 -> ch0 word accepted (cnt=1), ch1 word not accepted (ch_yumi_o=00), data_o unchanged; one cycle of yumi_i=1 -> next word loads the same cycle, valid_o stays 1.
3. Only ch1 valid for 5 cycles, rptr=0 -> no accepts, valid_o=0; ch0 valid at cycle 6 -> ch0 taken, then ch1 taken at cycle 7.
4. Idle, ch_en_i=01 -> en_r=01, rptr=0; ch0 words 0x1, 0x2 -> data_o=0x00000002_00000001; ch1 never yumi'd.
5. ch_en_i=00 while idle -> err_o=1 next cycle, no ch_yumi_o; restoring 11 -> err_o=0, rptr=0.
6. rst asserted with cnt=1 and valid_o=1 -> next cycle valid_o=0, data_o=0, rptr=0; the next assembled word contains no stale data.

Source files
------------

// File: rtl/bsg_down_pkg.sv
// Shared constants and helpers for the downstream core-side assembler.
package bsg_down_pkg;

  localparam int unsigned NUM_CH_DEF = 2;
  localparam int unsigned CH_W_DEF   = 32;
  localparam int unsigned WORDS_DEF  = 2;

  // Ceiling log2, never less than 1 so single-entry indices still have a bit.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    while ((r < 32) && ((32'd1 << r) < v)) r++;
    return r;
  endfunction

  typedef logic [clog2(NUM_CH_DEF)-1:0] ch_idx_t;

endpackage

// File: rtl/bsg_down_rr_next.sv
// Combinational channel search: next enabled channel after cur_i (circular)
// and lowest set bit of a reload mask.
module bsg_down_rr_next
  import bsg_down_pkg::*;
#(
  parameter int unsigned NUM_CH = NUM_CH_DEF
) (
  input  logic [NUM_CH-1:0]        en_i,
  input  logic [clog2(NUM_CH)-1:0] cur_i,
  input  logic [NUM_CH-1:0]        mask_i,
  output logic [clog2(NUM_CH)-1:0] next_c_o,
  output logic [clog2(NUM_CH)-1:0] low_c_o
);

  localparam int unsigned IW = clog2(NUM_CH);

  logic [IW-1:0] idx;
  logic          found;

  // Circular priority search starting at cur_i+1; wraps back to cur_i itself.
  always_comb begin
    next_c_o = cur_i;
    idx      = '0;
    found    = 1'b0;
    for (int i = 1; i <= int'(NUM_CH); i++) begin
      idx = IW'((int'(cur_i) + i) % int'(NUM_CH));
      if (!found && en_i[idx]) begin
        next_c_o = idx;
        found    = 1'b1;
      end
    end
  end

  // Lowest set bit of the mask; an all-zero mask yields channel 0.
  always_comb begin
    low_c_o = '0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (mask_i[i]) low_c_o = IW'(i);
    end
  end

endmodule

// File: rtl/bsg_down_assembler.sv
// Packs WORDS channel words, taken in strict round-robin order over the
// enabled channels, into one wide core word behind a valid/yumi register.
module bsg_down_assembler
  import bsg_down_pkg::*;
#(
  parameter int unsigned NUM_CH = NUM_CH_DEF,
  parameter int unsigned CH_W   = CH_W_DEF,
  parameter int unsigned WORDS  = WORDS_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH*CH_W-1:0]  ch_data_i,
  input  logic [NUM_CH-1:0]       ch_valid_i,
  output logic [NUM_CH-1:0]       ch_yumi_o,
  input  logic [NUM_CH-1:0]       ch_en_i,
  output logic [WORDS*CH_W-1:0]   data_o,
  output logic                    valid_o,
  input  logic                    yumi_i,
  output logic                    err_o
);

  localparam int unsigned IW    = clog2(NUM_CH);
  localparam int unsigned CW    = clog2(WORDS);
  localparam int unsigned OUT_W = WORDS * CH_W;
  localparam int unsigned ACC_W = (WORDS - 1) * CH_W;

  logic [NUM_CH-1:0] en_q, en_d;
  logic [IW-1:0]     rptr_q, rptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [OUT_W-1:0]  data_q, data_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;

  logic [IW-1:0]     rr_next, rr_low;
  logic [CH_W-1:0]   word;
  logic              last, room, accept;

  bsg_down_rr_next #(.NUM_CH(NUM_CH)) u_rr (
    .en_i     (en_q),
    .cur_i    (rptr_q),
    .mask_i   (ch_en_i),
    .next_c_o (rr_next),
    .low_c_o  (rr_low)
  );

  // Select the word on the current channel.
  always_comb begin
    word = '0;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      if (rptr_q == IW'(c)) word = ch_data_i[c*CH_W +: CH_W];
    end
  end

  // A completing word needs the output register free or draining this cycle.
  assign last   = (cnt_q == CW'(WORDS - 1));
  assign room   = !last || !valid_q || yumi_i;
  assign accept = ch_valid_i[rptr_q] && en_q[rptr_q] && room;

  // Consume handshake is one-hot on the current channel only.
  always_comb begin
    ch_yumi_o = '0;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      if (accept && (rptr_q == IW'(c))) ch_yumi_o[c] = 1'b1;
    end
  end

  // Next-state: accumulate, complete, drain and idle-time mask reload.
  always_comb begin
    en_d    = en_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    data_d  = data_q;
    valid_d = valid_q;

    if (accept) begin
      rptr_d = rr_next;
      if (last) begin
        data_d  = {word, acc_q};
        valid_d = 1'b1;
        cnt_d   = '0;
      end else begin
        for (int k = 0; k < int'(WORDS) - 1; k++) begin
          if (cnt_q == CW'(k)) acc_d[k*CH_W +: CH_W] = word;
        end
        cnt_d = cnt_q + CW'(1);
      end
    end

    if (!(accept && last) && yumi_i && valid_q) valid_d = 1'b0;

    if ((cnt_q == '0) && !accept && (ch_en_i != en_q)) begin
      en_d   = ch_en_i;
      rptr_d = rr_low;
    end

    err_d = (en_d == '0);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q    <= '1;
      rptr_q  <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      en_q    <= en_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_bsg_down_assembler.sv
// Scoreboard bench: channel streams and expected wide words are derived from
// the round-robin striping rule; a monitor checks handshakes and outputs.
module tb_bsg_down_assembler;
  import bsg_down_pkg::*;

  localparam int NUM_CH = int'(NUM_CH_DEF);
  localparam int CH_W   = int'(CH_W_DEF);
  localparam int WORDS  = int'(WORDS_DEF);
  localparam int OUT_W  = WORDS * CH_W;

  logic                   clk;
  logic                   rst;
  logic [NUM_CH*CH_W-1:0] ch_data_i;
  logic [NUM_CH-1:0]      ch_valid_i;
  logic [NUM_CH-1:0]      ch_yumi_o;
  logic [NUM_CH-1:0]      ch_en_i;
  logic [OUT_W-1:0]       data_o;
  logic                   valid_o;
  logic                   yumi_i;
  logic                   err_o;

  bsg_down_assembler dut (
    .clk        (clk),
    .rst        (rst),
    .ch_data_i  (ch_data_i),
    .ch_valid_i (ch_valid_i),
    .ch_yumi_o  (ch_yumi_o),
    .ch_en_i    (ch_en_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .yumi_i     (yumi_i),
    .err_o      (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference state
  logic [CH_W-1:0]   chq [NUM_CH][$];
  logic [OUT_W-1:0]  expq[$];
  logic [NUM_CH-1:0] m_en;
  int                pos;
  int                wcnt;
  int                yumi_seen;

  // Stimulus controls
  bit gen_on;
  bit hold_yumi;
  int vrate;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int nth_en(input logic [NUM_CH-1:0] m, input int n);
    int seen;
    seen = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (m[c]) begin
        if (seen == n) return c;
        seen++;
      end
    end
    return -1;
  endfunction

  function automatic bit chans_empty();
    for (int c = 0; c < NUM_CH; c++) if (chq[c].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Channel and core-side driver
  always @(negedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (gen_on && chq[c].size() > 0 && $urandom_range(1, 10) <= vrate) begin
        ch_valid_i[c] = 1'b1;
        ch_data_i[c*CH_W +: CH_W] = chq[c][0];
      end else begin
        ch_valid_i[c] = 1'b0;
        ch_data_i[c*CH_W +: CH_W] = $urandom;
      end
    end
    yumi_i = !rst && !hold_yumi && (valid_o === 1'b1) && ($urandom_range(1, 10) <= vrate);
  end

  // Monitor: samples just before each rising edge
  bit               exp_valid_next;
  bit               prev_valid, prev_yumi;
  logic [OUT_W-1:0] prev_data;
  always begin
    @(negedge clk);
    #4;
    if (rst) begin
      exp_valid_next = 1'b0;
      prev_valid     = 1'b0;
      prev_yumi      = 1'b0;
    end else begin
      if (exp_valid_next) check("latency_valid", valid_o, 1'b1);
      if (prev_valid && !prev_yumi) begin
        check("bp_data_stable", data_o, prev_data);
        check("bp_valid_held", valid_o, 1'b1);
      end
      if (yumi_i && !valid_o) begin
        failures++;
        $display("FAIL illegal_yumi actual=1 required=0");
      end
      if (valid_o && yumi_i) begin
        if (expq.size() == 0) begin
          failures++;
          $display("FAIL unexpected_output actual=%0h required=none", data_o);
        end else begin
          check("out_data", data_o, expq.pop_front());
        end
      end
      exp_valid_next = 1'b0;
      if (ch_yumi_o != '0) begin
        int c, n, want;
        yumi_seen++;
        check("yumi_onehot", $onehot(ch_yumi_o), 1'b1);
        c = 0;
        for (int i = 0; i < NUM_CH; i++) if (ch_yumi_o[i]) c = i;
        n = $countones(m_en);
        want = (n == 0) ? -1 : nth_en(m_en, pos);
        check("yumi_order", c, want);
        check("yumi_on_valid", ch_valid_i[c], 1'b1);
        if (chq[c].size() != 0) void'(chq[c].pop_front());
        if (n != 0) pos = (pos + 1) % n;
        if (wcnt == WORDS - 1) begin
          exp_valid_next = 1'b1;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end
      prev_valid = valid_o;
      prev_yumi  = yumi_i;
      prev_data  = data_o;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_mask(input logic [NUM_CH-1:0] m);
    if (m !== m_en) begin
      ch_en_i = m;
      m_en    = m;
      pos     = 0;
      step();
      step();
    end
  endtask

  // Queue nout wide words of striped traffic and push their expected packing.
  task automatic load_words(input logic [NUM_CH-1:0] m, input int nout, input int pat);
    int n, ch;
    int kc[NUM_CH];
    logic [CH_W-1:0]  w;
    logic [OUT_W-1:0] wacc;
    n = $countones(m);
    wacc = '0;
    for (int c = 0; c < NUM_CH; c++) kc[c] = 0;
    for (int k = 0; k < nout * WORDS; k++) begin
      ch = nth_en(m, (pos + k) % n);
      case (pat)
        1:       w = 32'hA000_0000 + 32'(ch) * 32'h1000_0000 + 32'(kc[ch]);
        2:       w = 32'(k + 1);
        default: w = $urandom;
      endcase
      kc[ch]++;
      chq[ch].push_back(w);
      wacc[(k % WORDS)*CH_W +: CH_W] = w;
      if (k % WORDS == WORDS - 1) expq.push_back(wacc);
    end
  endtask

  task automatic run_seg(input logic [NUM_CH-1:0] m, input int nout, input int pat,
                         input int rate, input string tag);
    int cyc;
    apply_mask(m);
    load_words(m, nout, pat);
    vrate  = rate;
    gen_on = 1'b1;
    cyc    = 0;
    while ((expq.size() != 0 || !chans_empty()) && cyc < 4000) begin
      step();
      cyc++;
    end
    gen_on = 1'b0;
    check({"drain_", tag}, (cyc >= 4000), 1'b0);
    if (rate == 10) check({"throughput_", tag}, (cyc <= nout * WORDS + 3), 1'b1);
    step();
  endtask

  initial begin
    int cyc, ys;
    logic [NUM_CH-1:0] rm;
    rst = 1'b1; ch_en_i = '1; m_en = '1; pos = 0; wcnt = 0; yumi_seen = 0;
    gen_on = 1'b0; hold_yumi = 1'b0; vrate = 7;
    ch_valid_i = '0; ch_data_i = '0; yumi_i = 1'b0;
    repeat (3) step();
    check("rst_valid", valid_o, 1'b0);
    check("rst_data", data_o, '0);
    check("rst_err", err_o, 1'b0);
    check("rst_yumi", ch_yumi_o, '0);
    rst = 1'b0;
    step();

    // Two-channel striping at full rate with recognisable words
    run_seg('1, 4, 1, 10, "pattern_full");
    run_seg('1, 6, 0, 6, "random_11");
    // Single enabled channel
    run_seg(NUM_CH'(1), 1, 2, 10, "mask_01");
    run_seg(NUM_CH'(2), 3, 0, 7, "mask_10");

    // All-zero mask flags an error and never consumes
    apply_mask('0);
    check("err_set", err_o, 1'b1);
    for (int c = 0; c < NUM_CH; c++) chq[c].push_back($urandom);
    ys = yumi_seen;
    vrate = 10; gen_on = 1'b1;
    repeat (5) step();
    gen_on = 1'b0;
    check("no_yumi_when_masked", yumi_seen, ys);
    for (int c = 0; c < NUM_CH; c++) chq[c].delete();
    step();
    apply_mask('1);
    check("err_clear", err_o, 1'b0);
    run_seg('1, 2, 1, 10, "after_restore");

    // Randomised masks, lengths and rates
    for (int s = 0; s < 8; s++) begin
      rm = NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1));
      run_seg(rm, $urandom_range(1, 5), 0, $urandom_range(3, 10), "random_seg");
    end
    run_seg('1, 1, 0, 10, "realign");

    // Backpressure, then reset with a partial word and a pending output
    hold_yumi = 1'b1;
    load_words('1, 2, 0);
    vrate = 10; gen_on = 1'b1;
    cyc = 0;
    while (!(valid_o === 1'b1 && wcnt == 1) && cyc < 50) begin
      step();
      cyc++;
    end
    repeat (4) step();
    check("bp_reached", (cyc < 50), 1'b1);
    check("bp_blocked_word", chq[nth_en(m_en, pos)].size(), 1);
    check("bp_pending_valid", valid_o, 1'b1);
    rst = 1'b1; gen_on = 1'b0; hold_yumi = 1'b0;
    for (int c = 0; c < NUM_CH; c++) chq[c].delete();
    expq.delete();
    m_en = '1; ch_en_i = '1; pos = 0; wcnt = 0;
    step();
    rst = 1'b0;
    check("midrst_valid", valid_o, 1'b0);
    check("midrst_data", data_o, '0);
    check("midrst_err", err_o, 1'b0);
    run_seg('1, 3, 0, 8, "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
